// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM port-B arbiter: default widths, owner encoding and helpers.
package vram_pkg;

  localparam int unsigned VramAddrW = 11;
  localparam int unsigned VramDataW = 32;
  localparam int unsigned RunW      = 8;
  localparam int unsigned MissW     = 16;

  // Owner of the grant issued in a cycle; also used as the read-return tag.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDisp = 2'd1,
    StEng  = 2'd2
  } owner_e;

  function automatic logic [MissW-1:0] sat_inc(input logic [MissW-1:0] v);
    return (v == '1) ? v : v + MissW'(1);
  endfunction

endpackage

// File: rtl/vram_rtag_pipe.sv
// Two-stage read-return tag pipeline: a read granted in cycle N raises rvalid for its owner in N+2.
module vram_rtag_pipe
  import vram_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  owner_e rd_owner_i,
  output logic   disp_rvalid_o,
  output logic   eng_rvalid_o
);

  owner_e s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= StIdle;
      s2_q <= StIdle;
    end else begin
      s1_q <= rd_owner_i;
      s2_q <= s1_q;
    end
  end

  assign disp_rvalid_o = (s2_q == StDisp);
  assign eng_rvalid_o  = (s2_q == StEng);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the shared VRAM port B between the display (priority) and the game engine,
// with a burst limit that guarantees the engine a slot while it waits.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W    = VramAddrW,
  parameter int unsigned DATA_W    = VramDataW,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [MissW-1:0]  disp_miss
);

  localparam logic [RunW-1:0] BurstLim = RunW'(MAX_BURST);

  owner_e          state_q, state_d, rd_owner;
  logic [RunW-1:0] run_q, run_d;
  logic            starve;

  always_comb begin
    starve   = eng_req && (run_q >= BurstLim);
    disp_gnt = !rst && disp_req && !starve;
    eng_gnt  = !rst && eng_req && !disp_gnt;
    state_d  = disp_gnt ? StDisp : (eng_gnt ? StEng : StIdle);
    // Engine writes occupy the port but must not produce a read return.
    rd_owner = (state_d == StEng && eng_we) ? StIdle : state_d;
    run_d    = run_q;
    if (eng_gnt || !eng_req) begin
      run_d = '0;
    end else if (disp_gnt && run_q != '1) begin
      run_d = run_q + RunW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      run_q     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      disp_miss <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ram_we  <= 1'b0;
      case (state_d)
        StDisp: ram_addr <= disp_addr;
        StEng: begin
          ram_addr <= eng_addr;
          ram_we   <= eng_we;
          ram_din  <= eng_wdata;
        end
        default: ;
      endcase
      if (disp_req && !disp_gnt) begin
        disp_miss <= sat_inc(disp_miss);
      end
    end
  end

  // A write on port B can only originate from an engine-owned cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!ram_we || state_q == StEng);
    end
  end

  vram_rtag_pipe u_rtag_pipe (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_owner_i   (rd_owner),
    .disp_rvalid_o(disp_rvalid),
    .eng_rvalid_o (eng_rvalid)
  );

  assign disp_rdata = disp_rvalid ? ram_dout : '0;
  assign eng_rdata  = eng_rvalid ? ram_dout : '0;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, VRAM word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, range 1..255, consecutive display grants allowed while the engine waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports disp_req in 1, disp_addr in ADDR_W: display read request and address.
REQ-007 SHALL have ports disp_gnt out 1, disp_rvalid out 1, disp_rdata out DATA_W: display grant, read-return strobe and read data.
REQ-008 SHALL have ports eng_req in 1, eng_we in 1, eng_addr in ADDR_W, eng_wdata in DATA_W: game-engine request, write enable, address and write data.
REQ-009 SHALL have ports eng_gnt out 1, eng_rvalid out 1, eng_rdata out DATA_W: engine grant, read-return strobe and read data.
REQ-010 SHALL have ports ram_addr out ADDR_W, ram_we out 1, ram_din out DATA_W, ram_dout in DATA_W: shared VRAM port B; reads are synchronous with 1-cycle latency.
REQ-011 SHALL have port disp_miss out 16: saturating count of display requests left ungranted.

Function
REQ-012 SHALL grant at most one requester per cycle; disp_gnt and eng_gnt are combinational from the current requests and registered state, and are never both 1.
REQ-013 SHALL give the display priority: when disp_req=1, disp_gnt=1 unless the starvation slot of REQ-015 applies.
REQ-014 SHALL set eng_gnt=1 whenever eng_req=1 and the display is not granted in that cycle.
REQ-015 SHALL keep an 8-bit run counter:
- Increments on each display grant while eng_req=1.
- Clears on any engine grant, or in any cycle with eng_req=0.
- When run counter >= MAX_BURST and eng_req=1, the engine is granted and the display is not.
REQ-016 SHALL implement owner FSM states IDLE, DISP and ENG, meaning the owner of the grant issued in the current cycle.
- Next state is DISP, ENG or IDLE per REQ-013..015.
- There are no other states.
REQ-017 SHALL register ram_addr, ram_we and ram_din at the end of the grant cycle N from the granted requester's addr, we and wdata.
- ram_we=1 only for a granted engine write, and only for one cycle.
- In IDLE, ram_we=0 and ram_addr/ram_din hold their values.
REQ-018 SHALL return read data 2 cycles after the grant.
- Grant of a read in cycle N gives a 1-cycle rvalid in N+2 to that requester only.
- rdata equals ram_dout in that cycle and is 0 otherwise.
- Engine writes produce no rvalid.
REQ-019 SHALL carry a 2-stage owner/read tag pipeline so back-to-back grants to alternating requesters each return in order, one per cycle.
REQ-020 SHALL increment disp_miss in each cycle with disp_req=1 and disp_gnt=0, saturating at 16'hFFFF.
REQ-021 SHALL accept a new grant every cycle, with no bubbles between grants.
REQ-022 SHALL let requesters hold or change requests freely; an ungranted request has no side effect except disp_miss.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force the following; it holds the same mid-operation and aborts in-flight reads:
- state=IDLE, run counter=0, tag pipeline empty;
- ram_addr=0, ram_we=0, ram_din=0, disp_miss=0;
- no rvalid in the two cycles following reset release.
REQ-024 SHALL force disp_gnt=0 and eng_gnt=0 while rst=1.

Structure
REQ-025 SHALL take ADDR_W/DATA_W defaults and the owner encoding (IDLE=2'd0, DISP=2'd1, ENG=2'd2) from shared package vram_pkg.
REQ-026 SHALL place the 2-stage read-return tag pipeline in one sub-module, vram_rtag_pipe.
REQ-027 SHALL contain no RAM; the VRAM stays external on port B.

Verification
REQ-028 SHALL cover: disp_req=1, addr=0x123 alone for 1 cycle -> disp_gnt same cycle; ram_addr=0x123 next cycle; disp_rvalid=1 with ram_dout two cycles after grant.
REQ-029 SHALL cover: disp_req and eng_req both held high, MAX_BURST=8 -> 8 display grants, then 1 engine grant with disp_miss=1, repeating; disp_miss=3 after 27 cycles.
REQ-030 SHALL cover: engine write addr=0x7FF, data=0xDEADBEEF with display idle -> eng_gnt=1; next cycle ram_we=1, ram_addr=0x7FF, ram_din=0xDEADBEEF; no eng_rvalid.
REQ-031 SHALL cover: alternating single-cycle display and engine reads over 6 cycles -> rvalids alternate display/engine at grant+2, each with matching data.
REQ-032 SHALL cover: rst asserted one cycle after a display read grant -> no disp_rvalid; all outputs at reset values; first grant after release behaves as the first scenario.
REQ-033 SHALL cover: disp_miss preloaded near saturation by forcing 65540 misses -> disp_miss holds 16'hFFFF.
